rx_data_fifo: RTL

Receive-side data buffer of the UART receiver, directly downstream of the receiver control unit. Captures each completed packet's data byte when the control unit pulses `load_buffer`. Holds up to DEPTH bytes in first-word-fall-through order for the host, and reports availability and overrun.

---
 rtl/rx_pkg.sv | 13 +
 rtl/rx_fifo_ptr.sv | 44 ++++
 rtl/rx_data_fifo.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared constants for the UART receive path.
//   RX_DATA_WIDTH : default width of one received data word
//   RX_IDLE_DATA  : value presented when no data is held (UART idle level)
// -----------------------------------------------------------------------------
package rx_pkg;

    localparam int RX_DATA_WIDTH = 8;

    localparam logic [RX_DATA_WIDTH-1:0] RX_IDLE_DATA = '1;

endpackage

// File: rtl/rx_fifo_ptr.sv
// -----------------------------------------------------------------------------
// rx_fifo_ptr
// Wrapping pointer counter for the receive FIFO. Advances by one on every
// clock edge where inc_i is high and wraps from 2**PTR_W-1 back to 0.
//
// Ports
//   clk    in   system clock, rising edge
//   n_rst  in   asynchronous active-low reset, pointer returns to 0
//   inc_i  in   increment enable
//   ptr_o  out  current pointer value, PTR_W bits
// -----------------------------------------------------------------------------
module rx_fifo_ptr
    import rx_pkg::*;
#(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Natural binary wrap: the FIFO depth is a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rx_data_fifo.sv
// -----------------------------------------------------------------------------
// rx_data_fifo
// Receive-side data buffer of the UART receiver. Captures the data byte of each
// completed packet on load_buffer and presents it to the host in
// first-word-fall-through order. Reports availability and a sticky overrun.
//
// Build option
//   RX_FIFO_OVERWRITE_EN : when defined, a write into a full buffer without a
//                          simultaneous read replaces the oldest entry; when
//                          undefined the incoming byte is dropped. Both cases
//                          set overrun_error.
//
// Ports
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   load_buffer    in   single-cycle write strobe from the receiver control
//   packet_data    in   data word sampled when load_buffer=1
//   data_read      in   host pop strobe, one entry per asserted cycle
//   rx_data        out  head entry, all-ones when empty
//   data_ready     out  high while at least one entry is held
//   overrun_error  out  sticky, set by a write into a full buffer, cleared by
//                       data_read (set wins over clear)
//   count          out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module rx_data_fifo
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_buffer,
    input  logic [DATA_WIDTH-1:0]    packet_data,
    input  logic                     data_read,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     data_ready,
    output logic                     overrun_error,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = '1;
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
            $error("rx_data_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Occupancy update kept in one place: +1, -1 or hold.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             up,
        input logic             dn
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (up && !dn) begin
            res = cur + CNT_W'(1);
        end else if (dn && !up) begin
            res = cur - CNT_W'(1);
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;

    logic                  full;
    logic                  empty;
    logic                  do_wr;
    logic                  do_rd;
    logic                  ovr_set;
    logic                  rptr_inc;
    logic                  cnt_up;
    logic                  cnt_dn;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A read on an empty buffer is silently ignored.
    assign do_rd   = data_read & ~empty;
    // Overrun is only a write into a full buffer that is not being drained in
    // the same cycle; write+read while full is a normal pass-through.
    assign ovr_set = load_buffer & full & ~data_read;

`ifdef RX_FIFO_OVERWRITE_EN
    // Overwrite mode: the write always lands, and on overrun the read pointer
    // is pushed forward so the oldest entry is discarded.
    assign do_wr    = load_buffer;
    assign rptr_inc = do_rd | ovr_set;
`else
    // Drop mode: a write into a full buffer lands only if a read frees a slot.
    assign do_wr    = load_buffer & (~full | data_read);
    assign rptr_inc = do_rd;
`endif

    // While full, a landed write either pairs with a read or overwrites, so
    // the count never grows past DEPTH.
    assign cnt_up = do_wr & ~do_rd & ~full;
    assign cnt_dn = do_rd & ~do_wr;

    always_comb begin
        count_d = next_count(count_q, cnt_up, cnt_dn);
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (data_read) begin
            overrun_d = 1'b0;
        end
    end

    rx_fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc_i (do_wr),
        .ptr_o (wptr)
    );

    rx_fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc_i (rptr_inc),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage returns to the idle level on reset so stale bytes never leak.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= IDLE_WORD;
            end
        end else if (do_wr) begin
            mem_q[wptr] <= packet_data;
        end
    end

    assign rx_data       = empty ? IDLE_WORD : mem_q[rptr];
    assign data_ready    = ~empty;
    assign overrun_error = overrun_q;
    assign count         = count_q;

endmodule
